// File: rtl/ooo_pkg.sv
// Shared types and helpers for the out-of-order writeback path.
//   wb_src_e   : which execute source produced a writeback result
//   wb_entry_t : one result record at the default widths
//   rob_age    : distance of a ROB slot from the current ROB head
//   is_younger : true when a slot is younger than a given branch slot
// The age helpers use a fixed 8-bit carrier plus an explicit width argument.
// This lets modules with any ROB_W up to ROB_W_MAX share them.
package ooo_pkg;

  localparam int ROB_W_MAX = 8;
  localparam int WB_DATA_W = 32;
  localparam int WB_ROB_W  = 3;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ROB_W-1:0]  rob_idx;
    logic                 valid;
  } wb_entry_t;

  typedef logic [ROB_W_MAX-1:0] rob_age_t;

  localparam logic [ROB_W_MAX:0] AGE_ONE = 1;

  // (idx - head) mod 2**rob_w
  function automatic rob_age_t rob_age(input rob_age_t idx, input rob_age_t head,
                                       input int rob_w);
    logic [ROB_W_MAX:0] span;
    rob_age_t           mask;
    span = AGE_ONE << rob_w;
    mask = rob_age_t'(span - AGE_ONE);
    return (idx - head) & mask;
  endfunction

  // An entry is younger than the branch when it sits further from the head.
  function automatic logic is_younger(input rob_age_t idx, input rob_age_t branch,
                                      input rob_age_t head, input int rob_w);
    return rob_age(idx, head, rob_w) > rob_age(branch, head, rob_w);
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small per-source result FIFO for the writeback arbiter.
//   clk, rst           : clock, synchronous active-low reset
//   push, push_data,
//   push_rob_idx       : offered result; it is taken only while count < DEPTH
//   pop                : remove the entry presented on out_*
//   flush,
//   flush_rob_idx,
//   rob_head           : squash every entry younger than the branch slot
//   out_valid, out_data,
//   out_rob_idx        : oldest-stored entry that survives this cycle's flush
//   count              : registered occupancy; the accept condition is count < DEPTH
// Storage is a circular buffer with wrapping head and tail pointers.
// On a flush, survivors are rewritten contiguously from the new head.
// So the buffer never holds holes, and count always equals the number of live entries.
module wb_skid_fifo
  import ooo_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic [ROB_W-1:0]        push_rob_idx,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [ROB_W-1:0]        flush_rob_idx,
  input  logic [ROB_W-1:0]        rob_head,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ROB_W-1:0]        out_rob_idx,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ROB_W-1:0]  mem_rob  [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] nxt_data [DEPTH];
  logic [ROB_W-1:0]  nxt_rob  [DEPTH];
  logic [PTR_W-1:0]  head_nxt;
  logic [PTR_W-1:0]  tail_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PTR_W-1:0]  sel;
  logic              accept;
  logic              popping;

  function automatic logic killed(input logic [ROB_W-1:0] idx, input logic fl,
                                  input logic [ROB_W-1:0] br, input logic [ROB_W-1:0] hd);
    return fl && is_younger(rob_age_t'(idx), rob_age_t'(br), rob_age_t'(hd), ROB_W);
  endfunction

  assign count   = cnt;
  assign accept  = push && (cnt < FULL);
  assign popping = pop && out_valid;

  // Present the first stored entry that survives the current flush.
  // This keeps a squashed head from ever reaching the output register.
  always_comb begin
    logic [PTR_W-1:0] pos;
    out_valid   = 1'b0;
    out_data    = '0;
    out_rob_idx = '0;
    sel         = '0;
    pos         = head;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (!out_valid && (CNT_W'(k) < cnt) &&
          !killed(mem_rob[pos], flush, flush_rob_idx, rob_head)) begin
        out_valid   = 1'b1;
        out_data    = mem_data[pos];
        out_rob_idx = mem_rob[pos];
        sel         = PTR_W'(k);
      end
    end
  end

  // Next contents: drop the popped entry and any squashed ones, pack the
  // rest from the new head, then append the accepted input unless it is squashed.
  always_comb begin
    logic [PTR_W-1:0] pos;
    logic [PTR_W-1:0] slot;
    nxt_data = mem_data;
    nxt_rob  = mem_rob;
    head_nxt = head + PTR_W'(popping);
    cnt_nxt  = '0;
    pos      = head;
    slot     = head_nxt;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if ((CNT_W'(k) < cnt) && !(popping && (PTR_W'(k) == sel)) &&
          !killed(mem_rob[pos], flush, flush_rob_idx, rob_head)) begin
        slot           = head_nxt + cnt_nxt[PTR_W-1:0];
        nxt_data[slot] = mem_data[pos];
        nxt_rob[slot]  = mem_rob[pos];
        cnt_nxt        = cnt_nxt + CNT_W'(1);
      end
    end
    if (accept && !killed(push_rob_idx, flush, flush_rob_idx, rob_head)) begin
      // Without a flush nothing moved, so the registered tail is the append point.
      slot           = flush ? (head_nxt + cnt_nxt[PTR_W-1:0]) : tail;
      nxt_data[slot] = push_data;
      nxt_rob[slot]  = push_rob_idx;
      cnt_nxt        = cnt_nxt + CNT_W'(1);
    end
    tail_nxt = head_nxt + cnt_nxt[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Payload needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_data <= nxt_data;
    mem_rob  <= nxt_rob;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto one registered WB port.
//   clk, rst                          : clock, synchronous active-low reset
//   alu_valid/alu_data/alu_rob_idx    : ALU result offer; alu_ready = ALU FIFO not full
//   lsu_valid/lsu_data/lsu_rob_idx    : LSU result offer; lsu_ready = LSU FIFO not full
//   flush, flush_rob_idx, rob_head    : squash everything younger than the branch slot
//   wb_valid/wb_data/wb_rob_idx/wb_src: registered writeback result (src 0 = ALU, 1 = LSU)
//   wb_ready                          : consumer takes the WB result this cycle
// Handshakes: a transfer happens at a rising edge where valid and ready are both high.
// A valid result is held stable until it transfers.
// A flush may withdraw a held result only if that result is younger than the branch.
module wb_arbiter
  import ooo_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ROB_W-1:0]  alu_rob_idx,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic [ROB_W-1:0]  lsu_rob_idx,
  output logic              lsu_ready,
  input  logic              flush,
  input  logic [ROB_W-1:0]  flush_rob_idx,
  input  logic [ROB_W-1:0]  rob_head,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [ROB_W-1:0]  wb_rob_idx,
  output logic              wb_src,
  input  logic              wb_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              alu_has, lsu_has;
  logic [DATA_W-1:0] alu_head_data, lsu_head_data;
  logic [ROB_W-1:0]  alu_head_rob, lsu_head_rob;
  logic [CNT_W-1:0]  alu_cnt, lsu_cnt;
  logic              alu_pop, lsu_pop;
  logic              load, contested, grant_any, grant_lsu, wb_kill;
  wb_src_e           rr_pref;

  wb_skid_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_alu_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (alu_valid),
    .push_data     (alu_data),
    .push_rob_idx  (alu_rob_idx),
    .pop           (alu_pop),
    .flush         (flush),
    .flush_rob_idx (flush_rob_idx),
    .rob_head      (rob_head),
    .out_valid     (alu_has),
    .out_data      (alu_head_data),
    .out_rob_idx   (alu_head_rob),
    .count         (alu_cnt)
  );

  wb_skid_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_lsu_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (lsu_valid),
    .push_data     (lsu_data),
    .push_rob_idx  (lsu_rob_idx),
    .pop           (lsu_pop),
    .flush         (flush),
    .flush_rob_idx (flush_rob_idx),
    .rob_head      (rob_head),
    .out_valid     (lsu_has),
    .out_data      (lsu_head_data),
    .out_rob_idx   (lsu_head_rob),
    .count         (lsu_cnt)
  );

  // Ready comes from registered occupancy only, so a pop at the same edge gives no credit.
  assign alu_ready = alu_cnt < FULL;
  assign lsu_ready = lsu_cnt < FULL;

  always_comb begin
    load      = !wb_valid || wb_ready;
    contested = alu_has && lsu_has;
    grant_any = load && (alu_has || lsu_has);
    grant_lsu = contested ? (rr_pref == WB_LSU) : lsu_has;
    alu_pop   = grant_any && !grant_lsu;
    lsu_pop   = grant_any && grant_lsu;
    wb_kill   = flush && wb_valid &&
                is_younger(rob_age_t'(wb_rob_idx), rob_age_t'(flush_rob_idx),
                           rob_age_t'(rob_head), ROB_W);
  end

  // rr_pref is the source that wins the next contested cycle.
  // It moves only when both sources actually competed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rob_idx <= '0;
      wb_src     <= 1'b0;
      rr_pref    <= WB_ALU;
    end else if (load) begin
      wb_valid <= grant_any;
      if (grant_any) begin
        wb_data    <= grant_lsu ? lsu_head_data : alu_head_data;
        wb_rob_idx <= grant_lsu ? lsu_head_rob  : alu_head_rob;
        wb_src     <= grant_lsu;
      end
      if (contested) begin
        rr_pref <= grant_lsu ? WB_ALU : WB_LSU;
      end
    end else if (wb_kill) begin
      wb_valid <= 1'b0;
    end
  end

endmodule
